fir_feeder: RTL and testbench

- Producer end of the FIR sample interface. Drives the filter's sample input and one-cycle input-ready strobe, and captures each filtered result on its output-ready strobe.
- Buffers host-written samples in a small FIFO.
- Launches a sample only when the filter is idle: after the previous result has returned and a programmable guard gap has elapsed.
- Presents each result to the host as a one-cycle valid pulse.

---
 rtl/fir_feeder.sv | 133 +++++++++++++
 tb/tb_fir_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_feeder.sv
// Producer side of the FIR sample interface: buffers host samples, launches one
// at a time into the filter once it is idle, and returns each result as a pulse.
module fir_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         fir_in,
  output logic                     fir_input_ready,
  input  logic [WIDTH-1:0]         fir_out,
  input  logic                     fir_output_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_valid,
  output logic                     busy,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(GAP + 1) + 1;

  // Handshake: wr_valid pushes only while wr_full is low; the filter is given
  // a one-cycle fir_input_ready strobe and answers with one fir_output_ready.
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [TW-1:0]    r_to_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [WIDTH-1:0] r_fir_in;
  logic             r_fir_input_ready;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_valid;
  logic             r_overflow;
  logic             r_timeout;
  logic             w_push;
  logic             w_pop;
  logic             w_res_hit;
  logic             w_to_hit;

  assign wr_full         = (r_level == LW'(DEPTH));
  assign level           = r_level;
  assign fir_in          = r_fir_in;
  assign fir_input_ready = r_fir_input_ready;
  assign res_data        = r_res_data;
  assign res_valid       = r_res_valid;
  assign busy            = (r_state != S_IDLE);
  assign overflow        = r_overflow;
  assign timeout         = r_timeout;
  assign w_push          = wr_valid && !wr_full;

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_res_hit = 1'b0;
    w_to_hit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_pop  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        // A result on the final count still wins over the timeout.
        if (fir_output_ready) begin
          w_res_hit = 1'b1;
          w_next    = S_GAP;
        end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          w_to_hit = 1'b1;
          w_next   = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GW'(GAP)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_level           <= '0;
      r_to_cnt          <= '0;
      r_gap_cnt         <= '0;
      r_fir_in          <= '0;
      r_fir_input_ready <= 1'b0;
      r_res_data        <= '0;
      r_res_valid       <= 1'b0;
      r_overflow        <= 1'b0;
      r_timeout         <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      // The filter samples fir_in a cycle after the strobe, so hold it until the next launch.
      if (r_state == S_IDLE && w_next == S_LAUNCH) r_fir_in <= r_mem[r_rd_ptr];
      r_fir_input_ready <= (w_next == S_LAUNCH);
      r_res_valid       <= w_res_hit;
      if (w_res_hit) r_res_data <= fir_out;
      if (wr_valid && wr_full) r_overflow <= 1'b1;
      if (w_to_hit) r_timeout <= 1'b1;
      if (r_state == S_LAUNCH)    r_to_cnt <= '0;
      else if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + TW'(1);
      if (r_state == S_WAIT) r_gap_cnt <= '0;
      else if (r_state == S_GAP && r_gap_cnt != GW'(GAP)) r_gap_cnt <= r_gap_cnt + GW'(1);
    end
  end

endmodule

// File: tb/tb_fir_feeder.sv
// Directed and randomized bench for fir_feeder with a filter stub and a
// convolution reference model driven from the host-side sample stream.
module tb_fir_feeder;
  localparam int WIDTH   = 16;
  localparam int DEPTH   = 8;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 64;

  logic        ck = 1'b0;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_full;
  logic [3:0]  level;
  logic [15:0] fir_in;
  logic        fir_input_ready;
  logic [15:0] fir_out = 16'h0;
  logic        fir_output_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_valid;
  logic        busy;
  logic        overflow;
  logic        timeout;

  always #5 ck = ~ck;

  fir_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .ck(ck), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_full(wr_full), .level(level), .fir_in(fir_in),
    .fir_input_ready(fir_input_ready), .fir_out(fir_out),
    .fir_output_ready(fir_output_ready), .res_data(res_data),
    .res_valid(res_valid), .busy(busy), .overflow(overflow), .timeout(timeout)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  int h_tab [16] = '{-81, -134, 317, 500, -900, 2000, 6000, 9000,
                     9000, 6000, 2000, -900, 500, 317, -134, -81};

  // Q15 FIR with round-half-up, truncated to 16 bits.
  function automatic logic [15:0] fir_model(input int xs[$], input int n);
    longint acc = 0;
    for (int k = 0; k < 16; k++)
      if (n - k >= 0) acc += longint'(h_tab[k]) * longint'(xs[n-k]);
    acc = (acc + 64'sd16384) >>> 15;
    return acc[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Filter stub: mode 0 never answers, 1 answers stub_val, 2 answers the FIR of what it sampled.
  int          stub_mode = 0;
  int          stub_lat = 19;
  logic [15:0] stub_val = 16'h0;
  logic        stub_kick = 1'b0;
  logic        pend = 1'b0;
  logic        hold_pend = 1'b0;
  logic [15:0] hold_val = 16'h0;
  int          due = 0;
  int          obs_q[$];
  logic [15:0] launch_q[$];
  int          strobe_cyc_q[$];

  always @(negedge ck) begin
    if (!rst_n) begin
      pend = 1'b0;
      hold_pend = 1'b0;
      fir_output_ready = 1'b0;
      obs_q.delete();
    end else begin
      fir_output_ready = 1'b0;
      if (hold_pend) begin
        chk("fir_in_hold", 32'(fir_in), 32'(hold_val));
        obs_q.push_back(int'($signed(fir_in)));
        hold_pend = 1'b0;
      end
      if (fir_input_ready) begin
        hold_pend = 1'b1;
        hold_val = fir_in;
        launch_q.push_back(fir_in);
        strobe_cyc_q.push_back(cyc);
        if (stub_mode != 0) begin
          pend = 1'b1;
          due = cyc + stub_lat;
        end
      end
      if (pend && cyc == due) begin
        pend = 1'b0;
        fir_output_ready = 1'b1;
        fir_out = (stub_mode == 1) ? stub_val : fir_model(obs_q, obs_q.size() - 1);
      end
      if (stub_kick) begin
        fir_output_ready = 1'b1;
        fir_out = 16'h5A5A;
      end
    end
  end

  // Scoreboard: every res_valid pulse must match the next expected result.
  logic [15:0] exp_q[$];
  logic [15:0] res_log[$];
  int          res_cnt = 0;

  always @(negedge ck) begin
    if (rst_n && res_valid) begin
      res_cnt++;
      res_log.push_back(res_data);
      if (exp_q.size() == 0) chk("res_unexpected", 32'(res_valid), 0);
      else chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic push(input logic [15:0] v);
    int n = 0;
    while (wr_full && n < 1000) begin tick(); n++; end
    if (n >= 1000) chk("push_wait", 32'(wr_full), 0);
    wr_data = v;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((busy || level != 0 || exp_q.size() != 0) && n < budget) begin tick(); n++; end
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_wr_full"}, 32'(wr_full), 0);
    chk({tag, "_fir_in"}, 32'(fir_in), 0);
    chk({tag, "_fir_input_ready"}, 32'(fir_input_ready), 0);
    chk({tag, "_res_data"}, 32'(res_data), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  int          model_x[$];
  int          s_cyc, r_cyc, t_push, t_to, base, r0, s0;
  logic [15:0] v;
  logic [15:0] lo [9];

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_data = 16'h0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Single sample, fixed stub response 19 cycles after the strobe.
    do_reset();
    stub_mode = 1; stub_lat = 19; stub_val = 16'h0ABC;
    exp_q.push_back(16'h0ABC);
    s0 = launch_q.size(); r0 = res_cnt;
    push(16'h1234);
    t_push = cyc; s_cyc = -1; r_cyc = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (fir_input_ready && s_cyc < 0) begin
        s_cyc = cyc;
        chk("t1_fir_in", 32'(fir_in), 32'h1234);
      end
      if (res_valid && r_cyc < 0) r_cyc = cyc;
    end
    chk("t1_strobes", launch_q.size() - s0, 1);
    chk("t1_launch_not_early", 32'(s_cyc >= t_push + 1), 1);
    chk("t1_res_latency", r_cyc - s_cyc, 20);
    chk("t1_res_cnt", res_cnt - r0, 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_fir_in_kept", 32'(fir_in), 32'h1234);

    // Impulse through the 16-tap model.
    do_reset();
    stub_mode = 2; stub_lat = 6;
    model_x.delete();
    r0 = res_log.size(); s0 = res_cnt;
    for (int i = 0; i < 16; i++) begin
      model_x.push_back(i == 0 ? 32767 : 0);
      exp_q.push_back(fir_model(model_x, i));
    end
    for (int i = 0; i < 16; i++) push(i == 0 ? 16'h7FFF : 16'h0);
    drain("t2", 3000);
    chk("t2_res0", 32'(res_log[r0]), 32'h0000FFAF);
    chk("t2_res1", 32'(res_log[r0+1]), 32'h0000FF7A);
    chk("t2_res2", 32'(res_log[r0+2]), 32'h0000013D);
    chk("t2_res_cnt", res_cnt - s0, 16);
    chk("t2_overflow", 32'(overflow), 0);
    chk("t2_timeout", 32'(timeout), 0);

    // Random samples, random latency and host pacing.
    do_reset();
    stub_mode = 2; stub_lat = $urandom_range(2, 30);
    model_x.delete();
    s0 = res_cnt;
    for (int i = 0; i < 12; i++) begin
      v = 16'($urandom);
      model_x.push_back(int'($signed(v)));
      exp_q.push_back(fir_model(model_x, i));
      push(v);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain("t2r", 3000);
    chk("t2r_res_cnt", res_cnt - s0, 12);

    // Fill and overflow while the first launch hangs in WAIT.
    do_reset();
    stub_mode = 0;
    base = launch_q.size(); s0 = res_cnt;
    push(16'h1000);
    repeat (3) tick();
    lo[0] = 16'h1000;
    for (int i = 0; i < 9; i++) begin
      wr_data = 16'h2000 + 16'(i);
      wr_valid = 1'b1;
      if (i < 8) lo[i+1] = wr_data;
      tick();
      if (i == 7) begin
        chk("t3_level_full", 32'(level), 8);
        chk("t3_wr_full", 32'(wr_full), 1);
        chk("t3_no_overflow_yet", 32'(overflow), 0);
      end
    end
    wr_valid = 1'b0;
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_level_sat", 32'(level), 8);
    drain("t3", 1000);
    chk("t3_overflow_sticky", 32'(overflow), 1);
    chk("t3_timeout", 32'(timeout), 1);
    chk("t3_launches", launch_q.size() - base, 9);
    for (int i = 0; i < 9; i++) chk("t3_order", 32'(launch_q[base+i]), 32'(lo[i]));
    chk("t3_no_res", res_cnt - s0, 0);

    // Timeout timing with two queued samples.
    do_reset();
    stub_mode = 0;
    base = strobe_cyc_q.size(); s0 = res_cnt; t_to = -1;
    push(16'h0111);
    push(16'h0222);
    for (int i = 0; i < 300 && (t_to < 0 || strobe_cyc_q.size() < base + 2); i++) begin
      tick();
      if (timeout === 1'b1 && t_to < 0) t_to = cyc;
    end
    chk("t4_timeout_delay", t_to - strobe_cyc_q[base], TIMEOUT + 1);
    chk("t4_second_launch", strobe_cyc_q[base+1] - t_to, GAP + 2);
    chk("t4_no_res", res_cnt - s0, 0);

    // Result on the last WAIT cycle beats the timeout; one cycle later it does not.
    do_reset();
    stub_mode = 1; stub_lat = TIMEOUT; stub_val = 16'h7777;
    exp_q.push_back(16'h7777);
    s0 = res_cnt;
    push(16'h0333);
    drain("t4b", 300);
    chk("t4b_timeout", 32'(timeout), 0);
    chk("t4b_res_cnt", res_cnt - s0, 1);
    do_reset();
    stub_lat = TIMEOUT + 1;
    s0 = res_cnt;
    push(16'h0444);
    drain("t4c", 300);
    chk("t4c_timeout", 32'(timeout), 1);
    chk("t4c_res_cnt", res_cnt - s0, 0);

    // Push on the LAUNCH cycle with level 3.
    do_reset();
    stub_mode = 1; stub_lat = 8; stub_val = 16'h1111;
    base = launch_q.size(); s0 = res_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h1111);
    push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
    for (int i = 0; i < 100 && !fir_input_ready; i++) tick();
    chk("t5_level_pre", 32'(level), 3);
    chk("t5_in_launch", 32'(fir_input_ready), 1);
    push(16'hA005);
    chk("t5_level_same", 32'(level), 3);
    drain("t5", 500);
    chk("t5_launches", launch_q.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("t5_order", 32'(launch_q[base+i]), 32'hA001 + i);
    chk("t5_res_cnt", res_cnt - s0, 5);

    // Reset mid-WAIT, then a late fir_output_ready.
    do_reset();
    stub_mode = 0;
    s0 = res_cnt;
    push(16'h0555);
    for (int i = 0; i < 20 && !fir_input_ready; i++) tick();
    repeat (5) tick();
    chk("t6_busy_wait", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    stub_kick = 1'b1;
    tick();
    stub_kick = 1'b0;
    repeat (5) tick();
    chk_reset_vals("t6");
    chk("t6_no_res", res_cnt - s0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
